rom_dmd_scheduler: RTL and testbench

//  Single-clock controller that owns the i4001 program ROM port and the dot-matrix load port.
//  In input mode (mode=0) it writes switch words into ROM at an auto-incrementing entry address.
//  In run/debug mode (mode=1/2) it continuously refreshes the DMD with the 32 columns of the

---
 rtl/rom_dmd_scheduler_pkg.sv | 33 +++
 rtl/rom_dmd_scheduler_page_counter.sv | 34 +++
 rtl/rom_dmd_scheduler.sv | 202 ++++++++++++++++++++
 tb/tb_rom_dmd_scheduler.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_dmd_scheduler_pkg.sv
// Shared constants, mode and FSM encodings for the ROM / dot-matrix scheduler.
package rom_dmd_scheduler_pkg;

    localparam int COLS     = 32;
    localparam int COL_W    = $clog2(COLS);
    localparam int MAX_PAGE = 63;
    localparam int PAGE_W   = 6;
    localparam int ADDR_W   = PAGE_W + COL_W;
    localparam int DATA_W   = 16;
    localparam int GAP      = 4;
    localparam int GAP_W    = $clog2(GAP + 1);

    typedef enum logic [1:0] {
        MODE_INPUT     = 2'd0,
        MODE_RUN       = 2'd1,
        MODE_DEBUG     = 2'd2,
        MODE_DEBUG_ALT = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WREQ = 3'd1,
        ST_RREQ = 3'd2,
        ST_LOAD = 3'd3,
        ST_GAPW = 3'd4
    } state_e;

    // Run and both debug encodings all refresh the display.
    function automatic logic is_refresh_mode(input logic [1:0] m);
        return mode_e'(m) != MODE_INPUT;
    endfunction

endpackage

// File: rtl/rom_dmd_scheduler_page_counter.sv
// Wrapping up/down page counter; an up and a down pulse in the same cycle cancel.
module rom_dmd_scheduler_page_counter
    import rom_dmd_scheduler_pkg::*;
#(
    parameter int WIDTH = PAGE_W,
    parameter int MAX   = MAX_PAGE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_up,
    input  logic             i_dn,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MAX);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_en && (i_up ^ i_dn)) begin
            if (i_up) begin
                r_count <= (r_count == LP_MAX) ? '0 : r_count + 1'b1;
            end else begin
                r_count <= (r_count == '0) ? LP_MAX : r_count - 1'b1;
            end
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/rom_dmd_scheduler.sv
// Arbitrates the program-ROM request/ack port between switch-panel writes and the
// continuous 32-column dot-matrix refresh scan.
module rom_dmd_scheduler
    import rom_dmd_scheduler_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [1:0]        mode,
    input  logic              wr_stb,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              entry_rst,
    input  logic              page_up,
    input  logic              page_dn,
    output logic              rom_req,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [DATA_W-1:0] rom_wdata,
    input  logic              rom_ack,
    input  logic [DATA_W-1:0] rom_rdata,
    output logic              dmd_load,
    output logic [COL_W-1:0]  dmd_col,
    output logic [DATA_W-1:0] dmd_data,
    output logic              dmd_clear,
    output logic [7:0]        page,
    output logic              busy,
    output logic              overrun
);

    state_e              r_state;
    logic                r_rom_req;
    logic                r_rom_we;
    logic [ADDR_W-1:0]   r_rom_addr;
    logic [DATA_W-1:0]   r_rom_wdata;
    logic                r_dmd_load;
    logic [COL_W-1:0]    r_dmd_col;
    logic [DATA_W-1:0]   r_dmd_data;
    logic                r_dmd_clear;
    logic [COL_W-1:0]    r_col;
    logic [PAGE_W-1:0]   r_scan_page;
    logic [GAP_W-1:0]    r_gap_cnt;
    logic                r_from_read;
    logic [ADDR_W-1:0]   r_entry_addr;
    logic                r_wr_pend;
    logic [DATA_W-1:0]   r_wr_data;
    logic                r_overrun;

    logic                w_refresh;
    logic                w_wr_ack;
    logic                w_wr_accept;
    logic [COL_W-1:0]    w_col_next;
    logic [PAGE_W-1:0]   w_view_page;

    assign w_refresh   = is_refresh_mode(mode);
    assign w_wr_ack    = (r_state == ST_WREQ) && rom_ack;
    assign w_wr_accept = wr_stb && !w_refresh;
    assign w_col_next  = r_col + 1'b1;

    rom_dmd_scheduler_page_counter #(
        .WIDTH (PAGE_W),
        .MAX   (MAX_PAGE)
    ) u_view_page (
        .clk     (CLK),
        .rst_n   (RESET_N),
        .i_en    (w_refresh),
        .i_up    (page_up),
        .i_dn    (page_dn),
        .o_count (w_view_page)
    );

    // The pending flag stays set until the ROM acknowledges, so a strobe in the ack cycle is dropped too.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_wr_pend <= 1'b0;
            r_wr_data <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_wr_ack) begin
                r_wr_pend <= 1'b0;
            end
            if (w_wr_accept && !r_wr_pend) begin
                r_wr_pend <= 1'b1;
                r_wr_data <= wr_data;
            end
            if (w_wr_accept && r_wr_pend) begin
                r_overrun <= 1'b1;
            end else if (entry_rst) begin
                r_overrun <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_entry_addr <= '0;
        end else if (entry_rst) begin
            r_entry_addr <= '0;
        end else if (w_wr_ack) begin
            r_entry_addr <= r_entry_addr + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state     <= ST_IDLE;
            r_rom_req   <= 1'b0;
            r_rom_we    <= 1'b0;
            r_rom_addr  <= '0;
            r_rom_wdata <= '0;
            r_dmd_load  <= 1'b0;
            r_dmd_col   <= '0;
            r_dmd_data  <= '0;
            r_dmd_clear <= 1'b0;
            r_col       <= '0;
            r_scan_page <= '0;
            r_gap_cnt   <= '0;
            r_from_read <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_col <= '0;
                    if (r_wr_pend) begin
                        r_state     <= ST_WREQ;
                        r_rom_req   <= 1'b1;
                        r_rom_we    <= 1'b1;
                        r_rom_addr  <= r_entry_addr;
                        r_rom_wdata <= r_wr_data;
                    end else if (w_refresh) begin
                        // The viewed page is frozen for the whole scan.
                        r_state     <= ST_RREQ;
                        r_rom_req   <= 1'b1;
                        r_rom_we    <= 1'b0;
                        r_rom_addr  <= {w_view_page, {COL_W{1'b0}}};
                        r_scan_page <= w_view_page;
                    end
                end
                ST_WREQ: begin
                    if (rom_ack) begin
                        r_state     <= ST_LOAD;
                        r_rom_req   <= 1'b0;
                        r_rom_we    <= 1'b0;
                        r_dmd_load  <= 1'b1;
                        r_dmd_col   <= r_rom_addr[COL_W-1:0];
                        r_dmd_data  <= r_rom_wdata;
                        r_dmd_clear <= (r_entry_addr[COL_W-1:0] == {COL_W{1'b1}}) && !entry_rst;
                        r_from_read <= 1'b0;
                    end
                end
                ST_RREQ: begin
                    if (rom_ack) begin
                        r_state     <= ST_LOAD;
                        r_rom_req   <= 1'b0;
                        r_dmd_load  <= 1'b1;
                        r_dmd_col   <= r_col;
                        r_dmd_data  <= rom_rdata;
                        r_from_read <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    r_dmd_load  <= 1'b0;
                    r_dmd_clear <= 1'b0;
                    if (!r_from_read || !w_refresh) begin
                        r_state <= ST_IDLE;
                    end else if (r_col == COL_W'(COLS - 1)) begin
                        r_state   <= ST_GAPW;
                        r_gap_cnt <= '0;
                    end else begin
                        r_state    <= ST_RREQ;
                        r_rom_req  <= 1'b1;
                        r_rom_we   <= 1'b0;
                        r_col      <= w_col_next;
                        r_rom_addr <= {r_scan_page, w_col_next};
                    end
                end
                ST_GAPW: begin
                    if (r_gap_cnt == GAP_W'(GAP - 1)) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_rom_req <= 1'b0;
                    r_rom_we  <= 1'b0;
                end
            endcase
        end
    end

    assign rom_req   = r_rom_req;
    assign rom_we    = r_rom_we;
    assign rom_addr  = r_rom_addr;
    assign rom_wdata = r_rom_wdata;
    assign dmd_load  = r_dmd_load;
    assign dmd_col   = r_dmd_col;
    assign dmd_data  = r_dmd_data;
    assign dmd_clear = r_dmd_clear;
    assign busy      = (r_state != ST_IDLE);
    assign overrun   = r_overrun;
    assign page      = w_refresh ? 8'(w_view_page) : 8'(r_entry_addr[ADDR_W-1:COL_W]);

endmodule

// File: tb/tb_rom_dmd_scheduler.sv
// Scoreboard bench: stimulus queues expected ROM requests and DMD loads, a monitor pops and compares.
module tb_rom_dmd_scheduler;

    typedef struct packed {
        logic        we;
        logic [10:0] addr;
        logic [15:0] wdata;
    } req_t;

    typedef struct packed {
        logic [4:0]  col;
        logic [15:0] data;
        logic        clr;
    } load_t;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        wr_stb = 1'b0;
    logic [15:0] wr_data = 16'h0;
    logic        entry_rst = 1'b0;
    logic        page_up = 1'b0;
    logic        page_dn = 1'b0;
    logic        rom_req;
    logic        rom_we;
    logic [10:0] rom_addr;
    logic [15:0] rom_wdata;
    logic        resp_ack = 1'b0;
    logic        force_ack = 1'b0;
    wire         rom_ack = resp_ack | force_ack;
    logic [15:0] rom_rdata = 16'h0;
    logic        dmd_load;
    logic [4:0]  dmd_col;
    logic [15:0] dmd_data;
    logic        dmd_clear;
    logic [7:0]  page;
    logic        busy;
    logic        overrun;

    rom_dmd_scheduler dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .mode      (mode),
        .wr_stb    (wr_stb),
        .wr_data   (wr_data),
        .entry_rst (entry_rst),
        .page_up   (page_up),
        .page_dn   (page_dn),
        .rom_req   (rom_req),
        .rom_we    (rom_we),
        .rom_addr  (rom_addr),
        .rom_wdata (rom_wdata),
        .rom_ack   (rom_ack),
        .rom_rdata (rom_rdata),
        .dmd_load  (dmd_load),
        .dmd_col   (dmd_col),
        .dmd_data  (dmd_data),
        .dmd_clear (dmd_clear),
        .page      (page),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 CLK = ~CLK;

    req_t  exp_req[$];
    load_t exp_load[$];
    int    n_checks = 0;
    int    n_fail = 0;
    logic  sb_en = 1'b1;
    logic  ack_en = 1'b1;
    int    ack_delay = 0;
    logic [10:0] entry_m = 11'd0;

    logic        mon_prev_req = 1'b0;
    logic        mon_ack_prev = 1'b0;
    logic [10:0] mon_held_addr = 11'd0;
    logic        mon_held_we = 1'b0;

    function automatic logic [15:0] rd_fn(input logic [10:0] a);
        return 16'h8000 | {5'b0, a};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic flag(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: actual=event required=none", name);
    endtask

    // ROM model: acknowledges ack_delay cycles after a request appears.
    initial begin : responder
        int wcnt;
        wcnt = 0;
        forever begin
            @(negedge CLK);
            if (resp_ack) begin
                resp_ack = 1'b0;
                wcnt = 0;
            end else if (rom_req && ack_en) begin
                if (wcnt >= ack_delay) begin
                    resp_ack = 1'b1;
                    rom_rdata = rd_fn(rom_addr);
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    initial begin : monitor
        req_t  er;
        load_t el;
        forever begin
            @(negedge CLK);
            #1;
            if (sb_en) begin
                if (rom_req && !mon_prev_req) begin
                    mon_held_addr = rom_addr;
                    mon_held_we = rom_we;
                    if (exp_req.size() == 0) begin
                        flag("unexpected_req");
                    end else begin
                        er = exp_req.pop_front();
                        check("req_we", 64'(rom_we), 64'(er.we));
                        check("req_addr", 64'(rom_addr), 64'(er.addr));
                        if (er.we) check("req_wdata", 64'(rom_wdata), 64'(er.wdata));
                    end
                end
                if (rom_req && rom_ack) begin
                    check("req_stable", {rom_we, rom_addr}, {mon_held_we, mon_held_addr});
                end
                if (dmd_load) begin
                    if (exp_load.size() == 0) begin
                        flag("unexpected_load");
                    end else begin
                        el = exp_load.pop_front();
                        $display("load col=%0d data=%h clr=%0d", dmd_col, dmd_data, dmd_clear);
                        check("load_col", 64'(dmd_col), 64'(el.col));
                        check("load_data", 64'(dmd_data), 64'(el.data));
                        check("load_clear", 64'(dmd_clear), 64'(el.clr));
                        check("load_latency", 64'(mon_ack_prev), 64'd1);
                    end
                end else if (dmd_clear) begin
                    flag("stray_clear");
                end
            end
            mon_prev_req = rom_req;
            mon_ack_prev = rom_req && rom_ack;
        end
    end

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic pulse_wr(input logic [15:0] d);
        wr_data = d;
        wr_stb = 1'b1;
        @(negedge CLK);
        wr_stb = 1'b0;
    endtask

    task automatic pulse_page(input logic up, input logic dn);
        page_up = up;
        page_dn = dn;
        @(negedge CLK);
        page_up = 1'b0;
        page_dn = 1'b0;
        #2;
    endtask

    task automatic wait_loads_left(input string name, input int left, input int budget);
        int n;
        n = 0;
        while (exp_load.size() > left && n < budget) begin
            @(negedge CLK);
            #2;
            n++;
        end
        if (exp_load.size() > left) check(name, 64'(exp_load.size()), 64'(left));
    endtask

    task automatic wait_drain(input string name, input int budget);
        wait_loads_left(name, 0, budget);
        if (exp_req.size() != 0) check({name, "_req"}, 64'(exp_req.size()), 64'd0);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge CLK);
            #2;
            n++;
        end
        if (busy) check(name, 64'(busy), 64'd0);
    endtask

    task automatic do_write(input logic [15:0] d);
        exp_req.push_back('{we: 1'b1, addr: entry_m, wdata: d});
        exp_load.push_back('{col: entry_m[4:0], data: d, clr: (entry_m[4:0] == 5'd31)});
        entry_m = entry_m + 11'd1;
        pulse_wr(d);
        wait_drain("write_done", 60);
    endtask

    task automatic push_scan(input logic [5:0] pg);
        for (int c = 0; c < 32; c++) begin
            exp_req.push_back('{we: 1'b0, addr: {pg, 5'(c)}, wdata: 16'h0});
            exp_load.push_back('{col: 5'(c), data: rd_fn({pg, 5'(c)}), clr: 1'b0});
        end
    endtask

    initial begin : stimulus
        int n;
        tick(3);
        #2;
        check("reset_outputs",
              {rom_req, rom_we, rom_addr, rom_wdata, dmd_load, dmd_col, dmd_data, dmd_clear, page, busy, overrun},
              64'd0);
        @(negedge CLK);
        RESET_N = 1'b1;
        tick(2);

        // single write with a 3-cycle ack
        ack_delay = 3;
        do_write(16'hA5A5);
        check("t1_page", 64'(page), 64'd0);

        // fill the first page, then wrap the whole ROM
        ack_delay = 0;
        for (int i = 1; i < 32; i++) do_write(16'h1000 + 16'(i));
        check("t2_page_after_32", 64'(page), 64'd1);
        for (int i = 32; i < 2016; i++) do_write(16'(i * 3));
        check("t2_page_63", 64'(page), 64'd63);
        for (int i = 2016; i < 2048; i++) do_write(16'(i * 3));
        check("t2_page_wrap", 64'(page), 64'd0);

        // view page wrap and cancel, scoreboard off while scanning
        sb_en = 1'b0;
        mode = 2'd1;
        tick(1);
        #2;
        check("t4_view_reset", 64'(page), 64'd0);
        pulse_page(1'b0, 1'b1);
        check("t4_dn_wrap", 64'(page), 64'd63);
        pulse_page(1'b1, 1'b0);
        check("t4_up_wrap", 64'(page), 64'd0);
        pulse_page(1'b1, 1'b1);
        check("t4_cancel", 64'(page), 64'd0);
        pulse_page(1'b1, 1'b0);
        pulse_page(1'b1, 1'b0);
        check("t4_page2", 64'(page), 64'd2);
        mode = 2'd0;
        pulse_page(1'b1, 1'b0);
        check("t4_mode0_entry_page", 64'(page), 64'd0);
        mode = 2'd3;
        tick(1);
        #2;
        check("t4_mode0_ignored", 64'(page), 64'd2);
        mode = 2'd0;
        wait_idle("t4_idle", 200);
        tick(2);
        sb_en = 1'b1;

        // refresh scans on page 2, page change mid second scan
        push_scan(6'd2);
        push_scan(6'd2);
        mode = 2'd1;
        wait_loads_left("t3_scan1", 32, 400);
        n = 0;
        while (!rom_req && n < 20) begin
            @(negedge CLK);
            #2;
            n++;
        end
        check("t3_gap_cycles", 64'(n), 64'd6);
        wait_loads_left("t3_mid_scan2", 27, 400);
        pulse_page(1'b1, 1'b0);
        check("t3_page3", 64'(page), 64'd3);
        push_scan(6'd3);
        wait_loads_left("t3_scan3", 0, 800);
        mode = 2'd0;
        wait_idle("t3_idle", 50);
        wait_drain("t3_drain", 10);

        // overrun with ack held off
        ack_en = 1'b0;
        exp_req.push_back('{we: 1'b1, addr: entry_m, wdata: 16'h1111});
        exp_load.push_back('{col: entry_m[4:0], data: 16'h1111, clr: 1'b0});
        entry_m = entry_m + 11'd1;
        pulse_wr(16'h1111);
        tick(1);
        pulse_wr(16'h2222);
        tick(1);
        #2;
        check("t5_overrun_set", 64'(overrun), 64'd1);
        check("t5_busy_held", {63'd0, busy}, 64'd1);
        ack_en = 1'b1;
        wait_drain("t5_first", 60);
        tick(4);
        #2;
        check("t5_no_second", 64'(busy), 64'd0);
        entry_rst = 1'b1;
        @(negedge CLK);
        entry_rst = 1'b0;
        #2;
        check("t5_overrun_clr", 64'(overrun), 64'd0);
        entry_m = 11'd0;
        do_write(16'h3333);

        // reset mid-request
        ack_en = 1'b0;
        exp_req.push_back('{we: 1'b1, addr: entry_m, wdata: 16'h4444});
        pulse_wr(16'h4444);
        n = 0;
        while (!rom_req && n < 20) begin
            @(negedge CLK);
            #2;
            n++;
        end
        check("t6_req_seen", 64'(rom_req), 64'd1);
        #1;
        RESET_N = 1'b0;
        #1;
        check("t6_req_async_drop", 64'(rom_req), 64'd0);
        check("t6_busy_reset", 64'(busy), 64'd0);
        entry_m = 11'd0;
        @(negedge CLK);
        force_ack = 1'b1;
        @(negedge CLK);
        RESET_N = 1'b1;
        tick(3);
        force_ack = 1'b0;
        tick(1);
        #2;
        check("t6_after_release", {rom_req, busy, overrun, page}, 64'd0);
        ack_en = 1'b1;
        do_write(16'h5555);
        tick(3);
        wait_drain("final_drain", 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
